// File: rtl/mmio_pkg.sv
// mmio_bus shared definitions: window defaults,
// FSM state encoding and device slot numbering.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_MASK_DEF = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int SLOT_SWITCH = 0;
    localparam int SLOT_ROM    = 1;
    localparam int SLOT_LED    = 2;
    localparam int SLOT_UART   = 3;

endpackage

// File: rtl/mmio_decode.sv
// mmio_bus address decoder: window match and
// device slot index extraction.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int          N_DEV     = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEF,
    parameter int          DEV_SHIFT = 8,
    parameter int          IDX_W     = 4
) (
    input  logic [31:0]      addr,
    output logic             in_window,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid
);

    localparam logic [31:0] N_DEV_U = 32'(N_DEV);

    // Window match, slot field extraction, slot range check
    always_comb begin
        in_window = (addr & MMIO_MASK) == MMIO_BASE;
        idx       = addr[DEV_SHIFT +: IDX_W];
        idx_valid = 32'(idx) < N_DEV_U;
    end

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: MMIO router with registered req/done
// handshake, timeout and error responses.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int          N_DEV     = 4,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEF,
    parameter int          DEV_SHIFT = 8,
    parameter int          IDX_W     = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                mmio_read,
    input  logic                mmio_write,
    input  logic [31:0]         mmio_addr,
    input  logic [31:0]         mmio_write_data,
    output logic                mmio_done,
    output logic [31:0]         mmio_read_data,
    output logic                mmio_err,
    output logic [N_DEV-1:0]    dev_req,
    output logic                dev_we,
    output logic [31:0]         dev_addr,
    output logic [31:0]         dev_wdata,
    input  logic [N_DEV-1:0]    dev_done,
    input  logic [N_DEV*32-1:0] dev_rdata
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [N_DEV-1:0]   req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               in_window;
    logic [IDX_W-1:0]   idx;
    logic               idx_valid;
    logic               accept;
    logic               bad_req;
    logic               sel_done;
    logic [31:0]        sel_rdata;
    logic               expired;

    mmio_decode #(
        .N_DEV     (N_DEV),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_MASK (MMIO_MASK),
        .DEV_SHIFT (DEV_SHIFT),
        .IDX_W     (IDX_W)
    ) u_decode (
        .addr      (mmio_addr),
        .in_window (in_window),
        .idx       (idx),
        .idx_valid (idx_valid)
    );

    // Request qualification and selected-slot done/data mux
    always_comb begin
        accept    = in_window && (mmio_read || mmio_write);
        bad_req   = (mmio_read && mmio_write) || !idx_valid;
        expired   = cnt_q == CNT_LAST;
        sel_done  = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_done  = dev_done[k];
                sel_rdata = dev_rdata[32*k +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = bad_req ? ST_RESP : ST_WAIT;
            ST_WAIT: if (sel_done || expired) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && bad_req) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (accept) begin
                    for (int k = 0; k < N_DEV; k++) begin
                        req_d[k] = idx == IDX_W'(k);
                    end
                    we_d    = mmio_write;
                    addr_d  = mmio_addr;
                    wdata_d = mmio_write_data;
                    idx_d   = idx;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (sel_done) begin
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    req_d   = '0;
                end else if (expired) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    req_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mmio_done      = done_q;
    assign mmio_err       = err_q;
    assign mmio_read_data = rdata_q;
    assign dev_req        = req_q;
    assign dev_we         = we_q;
    assign dev_addr       = addr_q;
    assign dev_wdata      = wdata_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed and random MMIO accesses,
// scoreboard monitor against a transaction-level model.
module tb_mmio_bus;

    localparam int N_DEV   = 4;
    localparam int TIMEOUT = 8;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic                sys_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mmio_read = 1'b0;
    logic                mmio_write = 1'b0;
    logic [31:0]         mmio_addr = '0;
    logic [31:0]         mmio_write_data = '0;
    logic                mmio_done;
    logic [31:0]         mmio_read_data;
    logic                mmio_err;
    logic [N_DEV-1:0]    dev_req;
    logic                dev_we;
    logic [31:0]         dev_addr;
    logic [31:0]         dev_wdata;
    logic [N_DEV-1:0]    dev_done = '0;
    logic [N_DEV*32-1:0] dev_rdata = '0;

    mmio_bus #(
        .N_DEV   (N_DEV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .mmio_read       (mmio_read),
        .mmio_write      (mmio_write),
        .mmio_addr       (mmio_addr),
        .mmio_write_data (mmio_write_data),
        .mmio_done       (mmio_done),
        .mmio_read_data  (mmio_read_data),
        .mmio_err        (mmio_err),
        .dev_req         (dev_req),
        .dev_we          (dev_we),
        .dev_addr        (dev_addr),
        .dev_wdata       (dev_wdata),
        .dev_done        (dev_done),
        .dev_rdata       (dev_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    int               delay = 0;
    bit               silent = 0;
    bit               spur_en = 0;
    logic [N_DEV-1:0] exp_req = '0;
    logic             exp_we = 1'b0;
    logic [31:0]      exp_addr = '0;
    logic [31:0]      exp_wdata = '0;
    int               exp_hold = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops expectations on every done pulse
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (mmio_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(mmio_done), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_err", 32'(mmio_err), 32'(e.err));
                    chk("resp_rdata", mmio_read_data, e.rdata);
                    chk("resp_latency", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("idle_err", 32'(mmio_err), 32'h0);
                chk("idle_rdata", mmio_read_data, 32'h0);
            end
        end
    end

    // Device model: fixed-delay or silent responder, spurious done on others
    int  age [N_DEV];
    int  hold = 0;
    bit  seen = 0;
    always @(negedge sys_clk) begin
        if (dev_req != '0) begin
            if (!seen) begin
                chk("dev_req", 32'(dev_req), 32'(exp_req));
                chk("dev_we", 32'(dev_we), 32'(exp_we));
                chk("dev_addr", dev_addr, exp_addr);
                chk("dev_wdata", dev_wdata, exp_wdata);
                seen = 1;
            end
            hold++;
        end else begin
            if (hold > 0 && exp_hold >= 0)
                chk("req_hold", 32'(hold), 32'(exp_hold));
            hold = 0;
            seen = 0;
        end
        for (int k = 0; k < N_DEV; k++) begin
            if (dev_req[k]) begin
                dev_done[k] = !silent && (age[k] == delay);
                age[k]++;
            end else begin
                age[k] = 0;
                dev_done[k] = spur_en && (dev_req != '0);
            end
        end
    end

    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int dly, input bit sil, input bit spur,
                          input bit fix, input logic [31:0] fdat);
        logic [31:0] slot [N_DEV];
        int   idx;
        int   lat;
        bit   win;
        bit   got;
        exp_t e;
        @(negedge sys_clk);
        idx = int'(addr[8 +: 4]);
        for (int k = 0; k < N_DEV; k++) begin
            slot[k] = $urandom();
            if (fix && k == idx) slot[k] = fdat;
            dev_rdata[32*k +: 32] = slot[k];
        end
        win     = (addr & MASK) == BASE;
        delay   = dly;
        silent  = sil;
        spur_en = spur;
        mmio_addr       = addr;
        mmio_write_data = wdata;
        if (!win || !(rd || wr)) begin
            exp_req  = '0;
            exp_hold = 0;
            mmio_read  = rd;
            mmio_write = wr;
            repeat (6) @(negedge sys_clk);
            mmio_read  = 1'b0;
            mmio_write = 1'b0;
            return;
        end
        if ((rd && wr) || idx >= N_DEV) begin
            exp_req  = '0;
            exp_hold = 0;
            e.err    = 1'b1;
            e.rdata  = 32'h0;
            lat      = 1;
        end else begin
            exp_req   = '0;
            exp_req[idx] = 1'b1;
            exp_we    = wr;
            exp_addr  = addr;
            exp_wdata = wdata;
            if (sil || dly >= TIMEOUT) begin
                e.err    = 1'b1;
                e.rdata  = 32'h0;
                lat      = TIMEOUT + 1;
                exp_hold = TIMEOUT;
            end else begin
                e.err    = 1'b0;
                e.rdata  = wr ? 32'h0 : slot[idx];
                lat      = dly + 2;
                exp_hold = dly + 1;
            end
        end
        e.cyc = cyc + lat;
        sb.push_back(e);
        mmio_read  = rd;
        mmio_write = wr;
        got = 0;
        for (int n = 0; n < TIMEOUT + 10 && !got; n++) begin
            @(negedge sys_clk);
            got = mmio_done;
        end
        chk("done_seen", 32'(got), 32'h1);
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_done", 32'(mmio_done), 32'h0);
        chk("rst_err", 32'(mmio_err), 32'h0);
        chk("rst_rdata", mmio_read_data, 32'h0);
        chk("rst_req", 32'(dev_req), 32'h0);
        chk("rst_we", 32'(dev_we), 32'h0);
        chk("rst_addr", dev_addr, 32'h0);
        chk("rst_wdata", dev_wdata, 32'h0);
        rst_n = 1'b1;

        access(1, 0, 32'hFFFF_0104, 32'h1234_5678, 0, 0, 0, 1, 32'hDEAD_BEEF);
        access(0, 1, 32'hFFFF_0008, 32'h0000_00A5, 3, 0, 0, 0, 32'h0);
        access(1, 0, 32'hFFFF_0500, 32'h0, 0, 0, 0, 0, 32'h0);
        access(1, 0, 32'h0000_1000, 32'h0, 0, 0, 0, 0, 32'h0);
        access(1, 0, 32'hFFFF_0200, 32'h0, 0, 1, 1, 0, 32'h0);
        access(1, 1, 32'hFFFF_0000, 32'h0, 0, 0, 0, 0, 32'h0);
        access(1, 0, 32'hFFFF_0300, 32'h0, 7, 0, 1, 0, 32'h0);
        access(0, 1, 32'hFFFF_0100, 32'hCAFE_0001, 8, 0, 0, 0, 32'h0);

        // Reset while a silent device holds the bus in WAIT
        @(negedge sys_clk);
        silent    = 1;
        spur_en   = 0;
        exp_req   = 4'b0100;
        exp_we    = 1'b0;
        exp_addr  = 32'hFFFF_0200;
        exp_wdata = 32'h5555_AAAA;
        exp_hold  = -1;
        mmio_addr       = 32'hFFFF_0200;
        mmio_write_data = 32'h5555_AAAA;
        mmio_read       = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(dev_req), 32'h0);
        chk("abort_done", 32'(mmio_done), 32'h0);
        mmio_read = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        access(1, 0, 32'hFFFF_0104, 32'h0, 1, 0, 0, 1, 32'h0BAD_F00D);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            int          m;
            logic        r, w;
            m = $urandom_range(0, 9);
            if (m == 0) a = $urandom() & 32'h7FFF_FFFF;
            else a = BASE | ($urandom_range(0, 5) << 8) | ($urandom() & 32'hFF);
            m = $urandom_range(0, 9);
            r = (m == 0) || (m >= 2 && m < 6);
            w = (m == 0) || (m >= 6);
            access(r, w, a, $urandom(), $urandom_range(0, 10),
                   $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                   0, 32'h0);
        end

        repeat (5) @(negedge sys_clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
